// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op_sel encodings,
// FSM state enum and op classification helpers.
package serial_alu_pkg;

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_illegal_op(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b111);
    endfunction

    function automatic logic is_arith_op(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_1.sv
// 1-bit ALU slice: one bit of PASS_B/ADD/SUB/AND/OR/XOR per evaluation.
// Combinational, no latency; no flow control. Illegal selects yield result=0, Cout=0.
module alu_1
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       Cin,
    input  logic [2:0] sel,
    output logic       result,
    output logic       Cout
);

    logic b_eff;

    // Subtraction is A + ~B + 1; the +1 arrives as the initial carry.
    assign b_eff = (sel == OP_SUB) ? ~b : b;

    always_comb begin
        result = 1'b0;
        Cout   = 1'b0;
        case (sel)
            OP_PASS_B: result = b;
            OP_ADD, OP_SUB: begin
                result = a ^ b_eff ^ Cin;
                Cout   = (a & b_eff) | (a & Cin) | (b_eff & Cin);
            end
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives one alu_1 slice LSB first over WIDTH cycles.
// Latency: res_valid rises WIDTH cycles after acceptance. Backpressure: result held in DONE
// until res_ready; op_ready only in IDLE, no queueing. Flags built only with SERIAL_ALU_FLAGS_EN.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_err
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             ready_q;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_shift;
    logic [2:0]       sel_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;
    logic             slice_res, slice_cout;

    // ready_q is 1 only in IDLE, so it alone qualifies acceptance.
    assign accept    = op_valid && ready_q;
    assign last_bit  = (state_q == RUN) && (cnt_q == LAST);
    assign res_shift = {slice_res, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    alu_1 u_slice (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .Cin    (carry_q),
        .sel    (sel_q),
        .result (slice_res),
        .Cout   (slice_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sel_q   <= OP_PASS_B;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            res_q   <= '0;
            sel_q   <= op_sel;
            carry_q <= (op_sel == OP_SUB);
            cnt_q   <= '0;
            err_q   <= is_illegal_op(op_sel);
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_shift;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q, neg_q, cflag_q, ovf_q;

    // On the last bit carry_q still holds the carry into the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (last_bit) begin
            zero_q  <= (res_shift == '0);
            neg_q   <= slice_res;
            cflag_q <= is_arith_op(sel_q) & slice_cout;
            ovf_q   <= is_arith_op(sel_q) & (carry_q ^ slice_cout);
        end
    end

    assign res_zero  = zero_q;
    assign res_neg   = neg_q;
    assign res_carry = cflag_q;
    assign res_ovf   = ovf_q;
`else
    assign res_zero  = 1'b0;
    assign res_neg   = 1'b0;
    assign res_carry = 1'b0;
    assign res_ovf   = 1'b0;
`endif

    assign op_ready  = ready_q;
    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign res_err   = err_q;

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits; legal range 2..64.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port op_valid, input, 1: request present.
REQ-005 Port op_ready, output, 1: sequencer can accept a request.
REQ-006 Port op_sel, input, 3: operation code; encodings are defined in REQ-033.
REQ-007 Port op_a and port op_b, inputs, WIDTH each: operands.
REQ-008 Port res_valid, output, 1: result present.
REQ-009 Port res_ready, input, 1: consumer takes the result.
REQ-010 Port res_data, output, WIDTH: result value.
REQ-011 Port res_zero, res_neg, res_carry and res_ovf, outputs, 1 each: status flags.
REQ-012 Port res_err, output, 1: the request carried an illegal op_sel.

Function
REQ-013 The block SHALL drive one 1-bit ALU slice bit-serially, LSB first, to produce a WIDTH-bit result.
REQ-014 The FSM SHALL have three states. IDLE goes to RUN on acceptance. RUN goes to DONE after WIDTH bit-cycles. DONE goes to IDLE when res_ready=1.
REQ-015 op_ready SHALL be 1 only in IDLE. Acceptance is an edge where op_valid=1 and op_ready=1.
REQ-016 On acceptance, the block SHALL capture op_a, op_b and op_sel. Input changes after acceptance SHALL have no effect.
REQ-017 The carry flop SHALL be initialised to 1 for SUB and to 0 for all other operations.
REQ-018 In each RUN cycle, the block SHALL present bit i of A and B plus the carry flop to the slice, register Cout into the carry flop, and shift the slice result into res_data from the MSB side.
REQ-019 A bit counter SHALL count 0..WIDTH-1. The RUN-to-DONE transition SHALL occur on the edge where the counter is WIDTH-1.
REQ-020 res_valid SHALL rise exactly WIDTH cycles after the acceptance edge.
REQ-021 In DONE, res_valid SHALL be 1, and res_data and all flags SHALL be held stable until res_ready=1.
REQ-022 res_zero SHALL equal (res_data == 0).
REQ-023 res_neg SHALL equal res_data[WIDTH-1].
REQ-024 res_carry SHALL be the final Cout for ADD and SUB, and 0 otherwise.
REQ-025 res_ovf SHALL be (carry into MSB) XOR (final Cout) for ADD and SUB, and 0 otherwise.
REQ-026 An illegal op_sel (001 or 111) SHALL still be accepted. It SHALL produce res_data=0, res_err=1, and the normal WIDTH-cycle latency.
REQ-027 If op_valid=1 while the block is busy, the request SHALL be ignored (op_ready=0). There is no queueing.
REQ-028 A DONE-to-IDLE transition SHALL not accept in the same cycle. op_ready SHALL rise on the cycle after the handshake.
REQ-029 Outputs SHALL be registered. No output may combinationally depend on op_valid or res_ready.

Reset
REQ-030 Asserting reset in any state, including mid-RUN, SHALL abort the operation and force IDLE.
REQ-031 While reset is asserted, op_ready=0, and res_valid, res_data, all flags and res_err SHALL be 0.
REQ-032 op_ready SHALL become 1 on the first clk edge after reset deasserts.

Configuration
REQ-033 The shared package SHALL define the op_sel encodings: PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110.
REQ-034 Macro SERIAL_ALU_FLAGS_EN, when defined, SHALL compute res_zero, res_neg, res_carry and res_ovf as specified above.
REQ-035 When SERIAL_ALU_FLAGS_EN is undefined, those four flag ports SHALL remain present and be tied to 0, and no flag logic shall be built. res_err SHALL be unaffected.

Structure
REQ-036 The package serial_alu_pkg SHALL hold the op_sel encoding constants, the FSM state enum (IDLE, RUN, DONE) and the illegal-op check function.
REQ-037 The datapath SHALL instantiate exactly one existing alu_1 slice as its only sub-module. The slice is driven via a, b, Cin and sel, and returns result and Cout.

Verification (WIDTH=64)
REQ-038 ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> res_data=0, zero=1, carry=1, ovf=0, res_valid exactly 64 cycles after acceptance.
REQ-039 SUB 5 - 7 -> res_data=0xFFFF_FFFF_FFFF_FFFE, neg=1, carry=0, ovf=0.
REQ-040 ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> res_data=0x8000_0000_0000_0000, ovf=1, neg=1.
REQ-041 XOR 0xA5A5 ^ 0xA5A5 with res_ready=0 for 10 cycles -> res_data=0 and zero=1 held stable; op_ready=0 and a second op_valid is ignored.
REQ-042 Reset asserted 30 cycles into an ADD -> all outputs 0 immediately; a fresh ADD 3 + 4 then returns 7.
REQ-043 op_sel=111 -> res_err=1, res_data=0, 64-cycle latency. With SERIAL_ALU_FLAGS_EN undefined, all four flags read 0 in every case.
